// File: rtl/axi4_lite_slv_template_if.sv
// AXI4-Lite bus bundle: one AW/W/B write path and one AR/R read path.
// Latency: none, wires only.
// Backpressure: carried by the valid/ready pairs of each channel.
interface axi4_lite_if #(
    parameter int ADDR_W = 4
) ();
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport slv_port (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport mst_port (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4_lite_slv_template.sv
// AXI4-Lite slave register file of 2**(ADDR_W-2) 32-bit registers; byte strobes honoured only with AXI4_LITE_SLV_WSTRB_EN.
// Latency: write accept one cycle after AW+W valid, B the cycle after; read accept one cycle after AR valid, R the cycle after.
// Backpressure: no new write while B is pending, no new read while R is pending; B/R held until bready/rready.
module axi4_lite_slv_template #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    axi4_lite_if.slv_port if_s_axi4_lite
);

    localparam int NUM_REGS = 2 ** (ADDR_W - 2);

    generate
        if (DATA_W != 32) begin : g_bad_data_w
            $error("axi4_lite_slv_template supports DATA_W = 32 only");
        end
    endgenerate

    logic [31:0]       regs [NUM_REGS];
    logic              awready_q;
    logic              bvalid_q;
    logic              arready_q;
    logic              rvalid_q;
    logic [31:0]       rdata_q;
    logic              wr_acc;
    logic              rd_acc;
    logic [ADDR_W-3:0] wr_idx;
    logic [ADDR_W-3:0] rd_idx;
    logic [31:0]       wr_mask;
    logic              unused_ok;

    // Both address and data must be present: the single ready pulse accepts them together.
    assign wr_acc = awready_q & if_s_axi4_lite.awvalid & if_s_axi4_lite.wvalid;
    assign rd_acc = arready_q & if_s_axi4_lite.arvalid;
    assign wr_idx = if_s_axi4_lite.awaddr[ADDR_W-1:2];
    assign rd_idx = if_s_axi4_lite.araddr[ADDR_W-1:2];

    assign if_s_axi4_lite.awready = awready_q;
    assign if_s_axi4_lite.wready  = awready_q;
    assign if_s_axi4_lite.bvalid  = bvalid_q;
    assign if_s_axi4_lite.bresp   = 2'b00;
    assign if_s_axi4_lite.arready = arready_q;
    assign if_s_axi4_lite.rvalid  = rvalid_q;
    assign if_s_axi4_lite.rdata   = rdata_q;
    assign if_s_axi4_lite.rresp   = 2'b00;

    // Protection bits and the byte offset within a register carry no meaning here.
`ifdef AXI4_LITE_SLV_WSTRB_EN
    assign unused_ok = ^{if_s_axi4_lite.awprot, if_s_axi4_lite.arprot,
                         if_s_axi4_lite.awaddr[1:0], if_s_axi4_lite.araddr[1:0]};
`else
    assign unused_ok = ^{if_s_axi4_lite.awprot, if_s_axi4_lite.arprot,
                         if_s_axi4_lite.awaddr[1:0], if_s_axi4_lite.araddr[1:0],
                         if_s_axi4_lite.wstrb};
`endif

    // Bit mask of the register bits an accepted write replaces.
    always_comb begin
        wr_mask = '1;
`ifdef AXI4_LITE_SLV_WSTRB_EN
        for (int k = 0; k < 4; k++) begin
            wr_mask[8*k +: 8] = {8{if_s_axi4_lite.wstrb[k]}};
        end
`endif
    end

    // Write handshake: ready pulses one cycle, B then holds until taken; no accept while B is pending.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
        end else begin
            awready_q <= ~awready_q & if_s_axi4_lite.awvalid & if_s_axi4_lite.wvalid & ~bvalid_q;
            if (wr_acc) begin
                bvalid_q <= 1'b1;
            end else if (if_s_axi4_lite.bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // Register storage, updated at the write accepting edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= 32'h0;
            end
        end else if (wr_acc) begin
            regs[wr_idx] <= (regs[wr_idx] & ~wr_mask) | (if_s_axi4_lite.wdata & wr_mask);
        end
    end

    // Read handshake: ready may rise in the cycle R is consumed so back-to-back reads take two cycles.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'h0;
        end else begin
            arready_q <= ~arready_q & if_s_axi4_lite.arvalid & (~rvalid_q | if_s_axi4_lite.rready);
            if (rd_acc) begin
                rvalid_q <= 1'b1;
                rdata_q  <= regs[rd_idx];
            end else if (if_s_axi4_lite.rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi4_lite_slv_template.sv
// Bench for axi4_lite_slv_template: vector table, handshake corner sequences, random traffic vs a register-array model.
// Latency: n/a.
// Backpressure: bready/rready are held low in dedicated sequences.
module tb_axi4_lite_slv_template;

    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi4_lite_if #(.ADDR_W(ADDR_W)) bus ();

    axi4_lite_slv_template #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .if_s_axi4_lite (bus)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] model [NUM_REGS];

    typedef struct {
        bit                is_wr;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        logic [3:0]        strb;
        logic [31:0]       exp;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: a register keeps each byte lane whose strobe is off (strobes only count when enabled).
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        logic [3:0]  en;
`ifdef AXI4_LITE_SLV_WSTRB_EN
        en = s;
`else
        en = 4'hF;
`endif
        r = old;
        for (int k = 0; k < 4; k++) begin
            if (en[k]) r[8*k +: 8] = d[8*k +: 8];
        end
        return r;
    endfunction

    task automatic axi_write(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] s,
                             input bit hold_b, input string tag);
        int n;
        bus.awaddr  = a;
        bus.awprot  = 3'($urandom);
        bus.wdata   = d;
        bus.wstrb   = s;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.awready && n < 50);
        chk({tag, " awready_seen"}, 32'(bus.awready), 32'd1);
        chk({tag, " wready_with_awready"}, 32'(bus.wready), 32'd1);
        if (!bus.awready) begin
            bus.awvalid = 1'b0;
            bus.wvalid  = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        @(negedge clk);
        chk({tag, " awready_one_cycle"}, 32'(bus.awready), 32'd0);
        chk({tag, " bvalid_next_cycle"}, 32'(bus.bvalid), 32'd1);
        chk({tag, " bresp"}, 32'(bus.bresp), 32'd0);
        if (!hold_b) begin
            bus.bready = 1'b1;
            @(posedge clk);
            #1;
            bus.bready = 1'b0;
        end
    endtask

    task automatic axi_read(input logic [ADDR_W-1:0] a, output logic [31:0] d, input string tag);
        int n;
        bus.araddr  = a;
        bus.arprot  = 3'($urandom);
        bus.arvalid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.arready && n < 50);
        chk({tag, " arready_seen"}, 32'(bus.arready), 32'd1);
        d = 32'hxxxxxxxx;
        if (!bus.arready) begin
            bus.arvalid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.arvalid = 1'b0;
        @(negedge clk);
        chk({tag, " rvalid"}, 32'(bus.rvalid), 32'd1);
        chk({tag, " rresp"}, 32'(bus.rresp), 32'd0);
        chk({tag, " arready_low_while_rvalid"}, 32'(bus.arready), 32'd0);
        d = bus.rdata;
        bus.rready = 1'b1;
        @(posedge clk);
        #1;
        bus.rready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, d1, d2;
        bit          ok;
        logic [ADDR_W-1:0] ra;
        logic [31:0] rd, rs;
        logic [3:0]  rst4;

        vecs[0]  = '{1'b1, 4'h0, 32'h12345678, 4'hF, 32'h0};
        vecs[1]  = '{1'b0, 4'h0, 32'h0,        4'h0, 32'h12345678};
        vecs[2]  = '{1'b1, 4'h1, 32'h87654321, 4'hF, 32'h0};
        vecs[3]  = '{1'b0, 4'h0, 32'h0,        4'h0, 32'h87654321};
        vecs[4]  = '{1'b1, 4'h4, 32'hA5A5A5A5, 4'hF, 32'h0};
        vecs[5]  = '{1'b1, 4'h8, 32'h5A5A5A5A, 4'hF, 32'h0};
        vecs[6]  = '{1'b1, 4'hC, 32'hDEADBEEF, 4'hF, 32'h0};
        vecs[7]  = '{1'b0, 4'h4, 32'h0,        4'h0, 32'hA5A5A5A5};
        vecs[8]  = '{1'b0, 4'h8, 32'h0,        4'h0, 32'h5A5A5A5A};
        vecs[9]  = '{1'b0, 4'hC, 32'h0,        4'h0, 32'hDEADBEEF};
        vecs[10] = '{1'b0, 4'h3, 32'h0,        4'h0, 32'h87654321};
        vecs[11] = '{1'b0, 4'hF, 32'h0,        4'h0, 32'hDEADBEEF};

        for (int i = 0; i < NUM_REGS; i++) model[i] = 32'h0;
        bus.awaddr = '0; bus.awprot = '0; bus.wdata = '0; bus.wstrb = '0;
        bus.araddr = '0; bus.arprot = '0; bus.bready = 1'b0; bus.rready = 1'b0;
        // Valids are driven high during reset: the slave must still keep every output low.
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;

        // Reset state
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("reset_handshakes", {27'd0, bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid}, 32'd0);
            chk("reset_rdata", bus.rdata, 32'h0);
            chk("reset_resps", {28'd0, bus.bresp, bus.rresp}, 32'd0);
        end
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) begin
            axi_read(4'(i * 4), d, "rst_rd");
            chk($sformatf("reset_reg%0d", i), d, 32'h0);
        end

        // Vector table: basic write/read and address aliasing
        foreach (vecs[i]) begin
            if (vecs[i].is_wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 1'b0, $sformatf("tbl_wr%0d", i));
                model[vecs[i].addr[3:2]] = merge(model[vecs[i].addr[3:2]], vecs[i].data, vecs[i].strb);
            end else begin
                axi_read(vecs[i].addr, d, $sformatf("tbl_rd%0d", i));
                chk($sformatf("tbl_rd%0d data", i), d, vecs[i].exp);
            end
        end

        // Write backpressure: second AW+W waits while B is held
        axi_write(4'h4, 32'h11112222, 4'hF, 1'b1, "bp_wr1");
        model[1] = merge(model[1], 32'h11112222, 4'hF);
        bus.awaddr = 4'h8; bus.wdata = 32'h33334444; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (bus.awready || bus.wready || !bus.bvalid) ok = 1'b0;
        end
        chk("bp_wr_stall", 32'(ok), 32'd1);
        bus.bready = 1'b1;
        @(posedge clk);
        #1;
        bus.bready = 1'b0;
        axi_write(4'h8, 32'h33334444, 4'hF, 1'b0, "bp_wr2");
        model[2] = merge(model[2], 32'h33334444, 4'hF);
        axi_read(4'h8, d, "bp_rd_check");
        chk("bp_wr2 data", d, model[2]);

        // Read backpressure: rvalid and rdata steady while rready is low
        bus.araddr = 4'h4; bus.arvalid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = bus.arready;
        end
        chk("bp_rd arready_seen", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        bus.arvalid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("bp_rd rvalid c%0d", c), 32'(bus.rvalid), 32'd1);
            chk($sformatf("bp_rd rdata c%0d", c), bus.rdata, model[1]);
        end
        bus.rready = 1'b1;
        @(posedge clk);
        #1;
        bus.rready = 1'b0;
        @(negedge clk);
        chk("bp_rd rvalid_cleared", 32'(bus.rvalid), 32'd0);

        // Skewed channels: AW alone for 3 cycles gets no ready
        bus.awaddr = 4'hC; bus.awvalid = 1'b1; bus.wvalid = 1'b0;
        ok = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.awready || bus.wready) ok = 1'b0;
        end
        chk("skew no_ready", 32'(ok), 32'd1);
        axi_write(4'hC, 32'h0BADF00D, 4'hF, 1'b0, "skew_wr");
        model[3] = merge(model[3], 32'h0BADF00D, 4'hF);
        axi_read(4'hC, d, "skew_rd");
        chk("skew data", d, model[3]);

        // Read and write of one register accepted together: read sees the old value
        d1 = model[1];
        fork
            axi_write(4'h4, 32'hCAFEBABE, 4'hF, 1'b0, "rw_wr");
            axi_read(4'h4, d, "rw_rd");
        join
        chk("same_cycle_rw old_value", d, d1);
        model[1] = merge(model[1], 32'hCAFEBABE, 4'hF);

        // Read accepted one cycle after the write: sees the new value
        fork
            axi_write(4'h4, 32'h600DCAFE, 4'hF, 1'b0, "raw_wr");
            begin
                @(posedge clk);
                #1;
                axi_read(4'h4, d2, "raw_rd");
            end
        join
        model[1] = merge(model[1], 32'h600DCAFE, 4'hF);
        chk("read_after_write new_value", d2, model[1]);

        // Random traffic against the model
        for (int it = 0; it < 150; it++) begin
            ra = 4'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                rd = $urandom;
                rs = $urandom;
                rst4 = rs[3:0];
                axi_write(ra, rd, rst4, 1'b0, "rnd_wr");
                model[ra[3:2]] = merge(model[ra[3:2]], rd, rst4);
            end else begin
                axi_read(ra, d, "rnd_rd");
                chk($sformatf("rnd_rd addr%0h", ra), d, model[ra[3:2]]);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        // Reset while B is pending: bvalid drops at once, registers clear
        axi_write(4'h4, 32'hDEADBEEF, 4'hF, 1'b1, "rst_mid_wr");
        @(negedge clk);
        chk("rst_mid bvalid_before", 32'(bus.bvalid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid bvalid_async_clear", 32'(bus.bvalid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) model[i] = 32'h0;
        axi_read(4'h4, d, "rst_mid_rd");
        chk("rst_mid reg1_cleared", d, 32'h0);

        // Byte strobes (only honoured when the strobe feature is built in)
        axi_write(4'h8, 32'hFFFFFFFF, 4'b0101, 1'b0, "strb_wr");
        axi_read(4'h8, d, "strb_rd");
`ifdef AXI4_LITE_SLV_WSTRB_EN
        chk("strb_0101", d, 32'h00FF00FF);
`else
        chk("strb_ignored", d, 32'hFFFFFFFF);
`endif
        axi_write(4'h8, 32'h12345678, 4'b0000, 1'b0, "strb0_wr");
        axi_read(4'h8, d, "strb0_rd");
`ifdef AXI4_LITE_SLV_WSTRB_EN
        chk("strb_0000_no_change", d, 32'h00FF00FF);
`else
        chk("strb_0000_full_write", d, 32'h12345678);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
